// File: rtl/imem_loader_if.sv
// Byte-stream ingress and imem write port of the instruction-memory loader.
// master = loader side, slave = stream source / imem side.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Assembles a length-prefixed little-endian byte stream into imem words; one write per 4 bytes, holds the core
// in reset until done. All outputs registered; in_ready follows state only, so a stalled source just holds the partial word.
module imem_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   imem_loader_if.master       bus,
   output logic                cpu_rst,
   output logic                busy,
   output logic                done,
   output logic                err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_FLUSH, S_DONE, S_ERR
   } state_t;

   localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

   state_t               state, state_nxt;
   logic [LEN_WIDTH-1:0] len;
   logic [LEN_WIDTH-1:0] word_cnt;
   logic [1:0]           byte_idx;
   logic [23:0]          sh;

   logic                 xfer;
   logic                 last_byte;
   logic                 last_word;
   logic [LEN_WIDTH-1:0] len_rx;

   assign xfer      = bus.in_valid && bus.in_ready;
   assign last_byte = (byte_idx == 2'd3);
   assign last_word = (word_cnt == len - LEN_WIDTH'(1));
   // low header byte sits in the top of the shift register after LEN0
   assign len_rx    = LEN_WIDTH'({bus.in_data, sh[23:16]});

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_nxt = S_LEN0;
         end
         S_LEN0: begin
            if (xfer) state_nxt = S_LEN1;
         end
         S_LEN1: begin
            if (xfer) begin
               if (len_rx == '0)
                  state_nxt = S_DONE;
               else if (33'(len_rx) > CAPACITY)
                  state_nxt = S_ERR;
               else
                  state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer && last_byte && last_word) state_nxt = S_FLUSH;
         end
         S_FLUSH: state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         bus.in_ready   <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         cpu_rst        <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         len            <= '0;
         word_cnt       <= '0;
         byte_idx       <= '0;
         sh             <= '0;
      end else begin
         state        <= state_nxt;
         bus.in_ready <= state_nxt inside {S_LEN0, S_LEN1, S_DATA};
         busy         <= state_nxt inside {S_LEN0, S_LEN1, S_DATA, S_FLUSH};
         done         <= (state_nxt == S_DONE);
         err          <= (state_nxt == S_ERR);
         cpu_rst      <= (state_nxt != S_DONE);
         bus.imem_we  <= 1'b0;

         if (xfer) begin
            case (state)
               S_LEN0: sh <= {bus.in_data, sh[23:8]};
               S_LEN1: begin
                  len      <= len_rx;
                  word_cnt <= '0;
                  byte_idx <= '0;
               end
               S_DATA: begin
                  if (last_byte) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_wdata <= {bus.in_data, sh};
                     bus.imem_addr  <= ADDR_WIDTH'(word_cnt);
                     word_cnt       <= word_cnt + LEN_WIDTH'(1);
                  end else begin
                     sh <= {bus.in_data, sh[23:8]};
                  end
                  byte_idx <= byte_idx + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed stimulus for imem_loader, checked by a write scoreboard fed from a byte-level image model.
module tb_imem_loader;
   localparam int AW  = 8;
   localparam int CAP = 1 << AW;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic cpu_rst, busy, done, err;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus();

   imem_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus),
      .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int errors = 0;
   int cyc = 0;
   logic [7:0] img[$];
   wr_t exp_q[$];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: every complete 4-byte group after the header is one word at its ordinal address.
   function automatic void push_expected(input int nbytes);
      int  len;
      wr_t e;
      longint d;
      len = int'(img[0]) + 256 * int'(img[1]);
      if (len > CAP) return;
      for (int w = 0; w < len; w++) begin
         int a = 2 + 4 * w;
         if (a + 3 < nbytes) begin
            d = longint'(img[a]) + 256 * longint'(img[a+1]) +
                65536 * longint'(img[a+2]) + 16777216 * longint'(img[a+3]);
            e.addr = w;
            e.data = d[31:0];
            exp_q.push_back(e);
         end
      end
   endfunction

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (bus.imem_we) begin
            if (exp_q.size() == 0) begin
               tests++;
               errors++;
               $display("FAIL unexpected_write: addr %0d data %h, required no write", bus.imem_addr, bus.imem_wdata);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
               check("write_data", bus.imem_wdata, e.data);
            end
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
      check({tag, "_imem_we"}, 32'(bus.imem_we), 0);
      check({tag, "_imem_addr"}, 32'(bus.imem_addr), 0);
      check({tag, "_imem_wdata"}, bus.imem_wdata, 0);
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"}, 32'(err), 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         check("ready_during_gap", 32'(bus.in_ready), 1);
         @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         tests++;
         errors++;
         $display("FAIL byte_accept_timeout: in_ready low for %0d cycles, required high", n);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_cpu_rst", 32'(cpu_rst), 1);
      check("start_done_clr", 32'(done), 0);
      check("start_err_clr", 32'(err), 0);
      check("start_busy", 32'(busy), 1);
   endtask

   // Called at the negedge right after the final byte was accepted.
   task automatic finish_check(input int len);
      if (len > 0 && len <= CAP) begin
         check("flush_we", 32'(bus.imem_we), 1);
         check("flush_done", 32'(done), 0);
         check("flush_ready", 32'(bus.in_ready), 0);
         @(negedge clk);
      end
      check("end_done", 32'(done), (len <= CAP) ? 1 : 0);
      check("end_err", 32'(err), (len > CAP) ? 1 : 0);
      check("end_cpu_rst", 32'(cpu_rst), (len <= CAP) ? 0 : 1);
      check("end_busy", 32'(busy), 0);
      check("end_in_ready", 32'(bus.in_ready), 0);
      check("end_we_low", 32'(bus.imem_we), 0);
   endtask

   task automatic run_image(input int gmin, input int gmax);
      int len, c0;
      len = int'(img[0]) + 256 * int'(img[1]);
      push_expected(img.size());
      c0 = cyc;
      do_start();
      foreach (img[i]) send_byte(img[i], $urandom_range(gmax, gmin));
      if (len == 0 && gmax == 0) check("empty_done_latency", 32'(cyc - c0), 3);
      finish_check(len);
   endtask

   task automatic make_image(input int len);
      img = {};
      img.push_back(8'(len));
      img.push_back(8'(len >> 8));
      for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom_range(255, 0)));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      fork
         monitor();
      join_none
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset_vals("reset");

      // Two-word image, full throughput, then the same with 3-cycle gaps
      img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hA5, 8'h00};
      run_image(0, 0);
      run_image(3, 3);

      // Empty image
      img = '{8'h00, 8'h00};
      run_image(0, 0);

      // Oversized header, then recovery
      img = '{8'h01, 8'h01};
      run_image(0, 0);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("err_ready_low", 32'(bus.in_ready), 0);
         check("err_sticky", 32'(err), 1);
      end
      bus.in_valid = 1'b0;
      make_image(1);
      run_image(0, 1);

      // Exactly full capacity
      make_image(CAP);
      run_image(0, 0);

      // Reset after 6 data bytes of a 2-word load
      make_image(2);
      push_expected(8);
      do_start();
      for (int i = 0; i < 8; i++) send_byte(img[i], 0);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("midload_rst");
      rst = 1'b0;
      @(negedge clk);
      run_image(0, 0);

      // Restart from DONE with DEADBEEF
      img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_image(0, 0);

      // start pulsed mid-DATA is ignored
      make_image(2);
      push_expected(img.size());
      do_start();
      for (int i = 0; i < 4; i++) send_byte(img[i], 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("mid_start_busy", 32'(busy), 1);
      check("mid_start_ready", 32'(bus.in_ready), 1);
      for (int i = 4; i < img.size(); i++) send_byte(img[i], 0);
      finish_check(2);

      // Random images
      for (int t = 0; t < 15; t++) begin
         make_image($urandom_range(6, 0));
         run_image(0, $urandom_range(2, 0));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Hardware writer for the single-cycle RISC-V core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes the words sequentially from word address 0 through the imem write port, and holds the core in reset until the program image is complete. On silicon this replaces the simulation-only backdoor preload of the imem array.

Parameters:
ADDR_WIDTH, 8, imem word-address width; capacity = 2**ADDR_WIDTH words
LEN_WIDTH, 16, width of the word-count header

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  arm a new load; honoured only in IDLE, DONE or ERR
in_valid  in  1  byte on in_data is valid
in_data  in  8  stream byte
in_ready  out  1  loader accepts a byte this cycle
imem_we  out  1  imem write enable, one-cycle pulse per word
imem_addr  out  ADDR_WIDTH  imem word address (core PC >> 2)
imem_wdata  out  32  assembled instruction word
cpu_rst  out  1  active-high reset to the core; high while not DONE
busy  out  1  load in progress (LEN0..FLUSH)
done  out  1  image fully written; sticky until next start or rst
err  out  1  header length exceeded capacity; sticky until next start or rst

Behaviour:
- Byte transfer occurs on a rising edge where in_valid && in_ready. in_ready is a registered function of state: 1 in LEN0, LEN1 and DATA; 0 otherwise.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0.
- Internal state: word counter (LEN_WIDTH bits), byte index 0..3 (2 bits), 24-bit byte shift register.
- Stream format: len_lo, len_hi, then len words, each sent b0 (LSB) first through b3.
- IDLE: cpu_rst=1. start -> LEN0 and clear done/err.
- LEN0: on transfer, capture low byte -> LEN1.
- LEN1: on transfer, form len. Then:
  - len==0 -> DONE.
  - len > 2**ADDR_WIDTH -> ERR.
  - otherwise -> DATA with word index 0 and byte index 0.
- DATA, on each transfer:
  - Byte index 0..2: shift the byte in.
  - Byte index 3: at the same edge set imem_wdata={in_data,b2,b1,b0}, imem_addr=word index, imem_we=1 for exactly the next cycle. Word index increments and byte index wraps to 0.
  - If this was word len-1 -> FLUSH. Otherwise remain in DATA; in_ready stays high, giving full throughput of 1 byte/cycle.
- FLUSH: imem_we=1 for the last word, in_ready=0; next edge -> DONE.
- DONE: done=1, cpu_rst=0 from the first DONE cycle, which is one cycle after the last imem_we pulse. start -> LEN0 with cpu_rst=1 and done=0 on the same edge.
- ERR: err=1, cpu_rst=1, in_ready=0, imem_we never asserted. Only start or rst leaves ERR.
- start in LEN0..FLUSH: ignored.
- in_valid low mid-word: the partial word is held, with no timeout.
- imem_addr and imem_wdata are held after a write until the next word write.
- rst mid-load: immediate return to reset values.
  - The partial word is discarded.
  - Words already written remain in imem.
  - cpu_rst stays 1.
- len == 2**ADDR_WIDTH: legal; the last write goes to address 2**ADDR_WIDTH-1 with no wrap.

Test Plan:
1. rst 2 cycles, start, stream 02 00 13 05 10 00 B3 05 A5 00 at in_valid=1 -> imem_we pulses with (addr 0, 00100513) then (addr 1, 00A505B3); done=1 and cpu_rst=0 exactly 1 cycle after the second pulse.
2. Same image with in_valid low for 3 cycles between every byte -> identical writes; no extra imem_we; in_ready high throughout DATA.
3. Header 00 00 -> no imem_we, DONE 3 cycles after start, cpu_rst=0.
4. ADDR_WIDTH=8, header 01 01 (257 words) -> err=1, cpu_rst=1, in_ready=0, no writes; then start plus a valid 1-word image -> err=0, done=1.
5. rst asserted after 6 data bytes of a 2-word load -> 1 write (addr 0) only; all outputs at reset values next cycle; a fresh start reloads correctly.
6. start pulsed in DONE followed by a 1-word image DEADBEEF (EF BE AD DE) -> cpu_rst=1 during reload, write addr 0 = DEADBEEF, done reasserts; start pulsed mid-DATA has no effect.
